// File: rtl/collision_manager.sv
// Player-vs-objects collision manager: per-object hit pulses once per frame, frame summary, saturating hit counter.
// collision is combinational; pulses and summary are registered (1 cycle). No backpressure: every pixel is evaluated.
module collision_manager #(
   parameter int NUM_OBJ = 4,
   parameter int X_W     = 11,
   parameter int Y_W     = 11,
   parameter int CNT_W   = 8,
   parameter int ID_W    = 4
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               drawing_request_player,
   input  logic [NUM_OBJ-1:0] drawing_request_obj,
   input  logic [NUM_OBJ-1:0] obj_enable,
   input  logic [X_W-1:0]     pixelX,
   input  logic [Y_W-1:0]     pixelY,
   input  logic               clear_count,
   output logic               collision,
   output logic [NUM_OBJ-1:0] hit_pulse,
   output logic               hit_any_pulse,
   output logic [NUM_OBJ-1:0] frame_hit_mask,
   output logic [ID_W-1:0]    first_hit_id,
   output logic [X_W-1:0]     first_hit_x,
   output logic [Y_W-1:0]     first_hit_y,
   output logic               summary_valid,
   output logic [CNT_W-1:0]   total_hits
);

   typedef enum logic [1:0] {WAIT_SOF, ARMED, HIT} state_t;

   state_t             state_q;
   logic [NUM_OBJ-1:0] hit_vec;
   logic [NUM_OBJ-1:0] flag_q, flag_d;
   logic [NUM_OBJ-1:0] hit_pulse_q, frame_mask_q;
   logic               hit_any_q, summary_valid_q;
   logic               active, first_hit_d;
   logic [ID_W-1:0]    low_id_d, cap_id_q, first_id_q;
   logic [X_W-1:0]     cap_x_q, first_x_q;
   logic [Y_W-1:0]     cap_y_q, first_y_q;
   logic [CNT_W-1:0]   cnt_q;

   // A startOfFrame cycle belongs to the new frame: flags are seen as already cleared.
   always_comb begin
      hit_vec     = {NUM_OBJ{drawing_request_player}} & drawing_request_obj & obj_enable;
      active      = startOfFrame || (state_q != WAIT_SOF);
      flag_d      = startOfFrame ? '0 : flag_q;
      first_hit_d = active && (|hit_vec) && (startOfFrame || (state_q != HIT));
      low_id_d    = '0;
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         if (hit_vec[i]) low_id_d = ID_W'(i);
      end
   end

   assign collision = |hit_vec;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q         <= WAIT_SOF;
         flag_q          <= '0;
         hit_pulse_q     <= '0;
         hit_any_q       <= 1'b0;
         summary_valid_q <= 1'b0;
         frame_mask_q    <= '0;
         cap_id_q        <= '0;
         cap_x_q         <= '0;
         cap_y_q         <= '0;
         first_id_q      <= '0;
         first_x_q       <= '0;
         first_y_q       <= '0;
         cnt_q           <= '0;
      end else begin
         hit_pulse_q     <= active ? (hit_vec & ~flag_d) : '0;
         hit_any_q       <= first_hit_d;
         summary_valid_q <= 1'b0;
         if (active) flag_q <= flag_d | hit_vec;

         // Close the previous frame before this cycle's hits are credited to the new one.
         if (startOfFrame && (state_q != WAIT_SOF)) begin
            frame_mask_q    <= flag_q;
            first_id_q      <= cap_id_q;
            first_x_q       <= cap_x_q;
            first_y_q       <= cap_y_q;
            summary_valid_q <= 1'b1;
         end

         if (first_hit_d) begin
            cap_id_q <= low_id_d;
            cap_x_q  <= pixelX;
            cap_y_q  <= pixelY;
         end else if (startOfFrame) begin
            cap_id_q <= '0;
            cap_x_q  <= '0;
            cap_y_q  <= '0;
         end

         case (state_q)
            WAIT_SOF, HIT: if (startOfFrame) state_q <= collision ? HIT : ARMED;
            ARMED:         if (collision) state_q <= HIT;
            default:       state_q <= WAIT_SOF;
         endcase

         if (clear_count)                        cnt_q <= '0;
         else if (hit_any_q && (cnt_q != '1))    cnt_q <= cnt_q + 1'b1;
      end
   end

   assign hit_pulse      = hit_pulse_q;
   assign hit_any_pulse  = hit_any_q;
   assign frame_hit_mask = frame_mask_q;
   assign first_hit_id   = first_id_q;
   assign first_hit_x    = first_x_q;
   assign first_hit_y    = first_y_q;
   assign summary_valid  = summary_valid_q;
   assign total_hits     = cnt_q;

endmodule

// File: tb/tb_collision_manager.sv
// Scoreboard bench for collision_manager: frame-level reference model, randomized frames plus directed corner cases.
module tb_collision_manager;
   localparam int N  = 4;
   localparam int XW = 11;
   localparam int YW = 11;
   localparam int CW = 2;
   localparam int IW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          resetN;
   logic          startOfFrame, drawing_request_player, clear_count;
   logic [N-1:0]  drawing_request_obj, obj_enable;
   logic [XW-1:0] pixelX;
   logic [YW-1:0] pixelY;
   logic          collision, hit_any_pulse, summary_valid;
   logic [N-1:0]  hit_pulse, frame_hit_mask;
   logic [IW-1:0] first_hit_id;
   logic [XW-1:0] first_hit_x;
   logic [YW-1:0] first_hit_y;
   logic [CW-1:0] total_hits;

   always #5 clk = ~clk;

   collision_manager #(.NUM_OBJ(N), .X_W(XW), .Y_W(YW), .CNT_W(CW), .ID_W(IW)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .drawing_request_player(drawing_request_player), .drawing_request_obj(drawing_request_obj),
      .obj_enable(obj_enable), .pixelX(pixelX), .pixelY(pixelY), .clear_count(clear_count),
      .collision(collision), .hit_pulse(hit_pulse), .hit_any_pulse(hit_any_pulse),
      .frame_hit_mask(frame_hit_mask), .first_hit_id(first_hit_id), .first_hit_x(first_hit_x),
      .first_hit_y(first_hit_y), .summary_valid(summary_valid), .total_hits(total_hits));

   typedef struct packed { logic [N-1:0] mask; logic any; } pulse_t;
   typedef struct packed { logic [N-1:0] mask; logic [IW-1:0] id; logic [XW-1:0] x; logic [YW-1:0] y; } sum_t;

   pulse_t pq[$];
   sum_t   sq[$];
   int     nchk = 0;
   int     nerr = 0;

   // Reference model: set of objects hit this frame, first hit record, hit-frame count.
   bit           m_started;
   logic [N-1:0] m_mask;
   bit           m_has;
   int           m_id, m_x, m_y, m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_started = 0; m_mask = '0; m_has = 0; m_id = 0; m_x = 0; m_y = 0; m_cnt = 0;
   endfunction

   task automatic step(input bit sof, input bit pl, input logic [N-1:0] obj, input logic [N-1:0] en,
                       input int x, input int y, input bit clr);
      logic [N-1:0] hv, nw;
      @(posedge clk); #1;
      startOfFrame = sof; drawing_request_player = pl; drawing_request_obj = obj;
      obj_enable = en; pixelX = XW'(x); pixelY = YW'(y); clear_count = clr;
      hv = pl ? (obj & en) : '0;
      if (sof) begin
         if (m_started) sq.push_back({m_mask, IW'(m_id), XW'(m_x), YW'(m_y)});
         m_started = 1; m_mask = '0; m_has = 0; m_id = 0; m_x = 0; m_y = 0;
      end
      if (m_started && hv != '0) begin
         nw = hv & ~m_mask;
         if (nw != '0 || !m_has) pq.push_back({nw, !m_has});
         if (!m_has) begin
            m_has = 1; m_x = x; m_y = y;
            m_id = 0;
            while (!hv[m_id]) m_id++;
            if (m_cnt < CMAX) m_cnt++;
         end
         m_mask = m_mask | hv;
      end
      if (clr) m_cnt = 0;
      #1 chk("collision", collision, hv != '0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '1, 0, 0, 0);
   endtask

   task automatic chk_cnt(input string name);
      idle(3);
      chk(name, total_hits, m_cnt);
   endtask

   always @(negedge clk) begin
      if (resetN === 1'b1) begin
         if (hit_pulse != '0 || hit_any_pulse) begin
            if (pq.size() == 0) begin
               nchk++; nerr++;
               $display("FAIL pulse_unexpected: got mask=%b any=%b expected none (t=%0t)", hit_pulse, hit_any_pulse, $time);
            end else begin
               pulse_t e;
               e = pq.pop_front();
               chk("hit_pulse", hit_pulse, e.mask);
               chk("hit_any_pulse", hit_any_pulse, e.any);
            end
         end
         if (summary_valid) begin
            if (sq.size() == 0) begin
               nchk++; nerr++;
               $display("FAIL summary_unexpected: got mask=%b expected none (t=%0t)", frame_hit_mask, $time);
            end else begin
               sum_t s;
               s = sq.pop_front();
               chk("frame_hit_mask", frame_hit_mask, s.mask);
               chk("first_hit_id", first_hit_id, s.id);
               chk("first_hit_x", first_hit_x, s.x);
               chk("first_hit_y", first_hit_y, s.y);
            end
         end
      end
   end

   initial begin
      resetN = 1'b0; startOfFrame = 0; drawing_request_player = 0; drawing_request_obj = '0;
      obj_enable = '1; pixelX = '0; pixelY = '0; clear_count = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_hit_pulse", hit_pulse, 0);
      chk("rst_hit_any", hit_any_pulse, 0);
      chk("rst_mask", frame_hit_mask, 0);
      chk("rst_id", first_hit_id, 0);
      chk("rst_x", first_hit_x, 0);
      chk("rst_y", first_hit_y, 0);
      chk("rst_summary_valid", summary_valid, 0);
      chk("rst_total_hits", total_hits, 0);
      chk("rst_collision", collision, 0);
      @(posedge clk); #1 resetN = 1'b1;

      // Overlap before the first frame starts is ignored.
      for (int i = 0; i < 5; i++) step(0, 1, 4'b0001, '1, 10 + i, 3, 0);
      chk_cnt("pre_sof_total_hits");

      // Single object overlapping a 20-pixel run.
      step(1, 0, '0, '1, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 1, 4'b0010, '1, 100 + i, 50, 0);
      idle(4);
      // Two objects at once, another later in the same frame.
      step(1, 0, '0, '1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 4'b1100, '1, 7 + i, 9, 0);
      idle(5);
      step(0, 1, 4'b0001, '1, 30, 9, 0);
      step(0, 1, 4'b0001, '1, 31, 9, 0);
      idle(3);
      // Disabled object produces nothing.
      step(1, 0, '0, '1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 4'b0010, 4'b1101, 200 + i, 60, 0);
      idle(3);
      // Hit coincident with startOfFrame goes to the new frame.
      step(1, 1, 4'b0001, '1, 55, 66, 0);
      idle(4);
      step(1, 0, '0, '1, 0, 0, 0);
      idle(3);
      chk_cnt("saturated_total_hits");

      // Clear held across the hit and its pulse: clear wins.
      step(0, 1, 4'b0100, '1, 5, 5, 1);
      step(0, 0, '0, '1, 0, 0, 1);
      chk_cnt("clear_total_hits");

      // Count back up to saturation from zero.
      for (int f = 0; f < 5; f++) begin
         step(1, 0, '0, '1, 0, 0, 0);
         step(0, 1, 4'b1000, '1, f, f, 0);
         idle(2);
         if (f == 1) chk_cnt("count_two");
      end
      chk_cnt("count_sat");

      // Randomized frames.
      for (int f = 0; f < 40; f++) begin
         int len;
         len = $urandom_range(8, 30);
         for (int c = 0; c < len; c++) begin
            logic [N-1:0] o, e;
            o = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            e = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '1;
            step(c == 0, $urandom_range(0, 2) == 0, o, e, $urandom_range(0, 2047), $urandom_range(0, 2047), 0);
         end
      end
      step(1, 0, '0, '1, 0, 0, 0);
      chk_cnt("random_total_hits");

      // Reset mid-frame: partial frame yields no summary.
      step(0, 1, 4'b0010, '1, 9, 9, 0);
      idle(3);
      @(posedge clk); #1 resetN = 1'b0;
      model_reset();
      #2 chk("midrst_total_hits", total_hits, 0);
      chk("midrst_mask", frame_hit_mask, 0);
      @(posedge clk); #1 resetN = 1'b1;
      step(1, 0, '0, '1, 0, 0, 0);
      step(0, 1, 4'b0100, '1, 12, 34, 0);
      idle(2);
      step(1, 0, '0, '1, 0, 0, 0);
      idle(4);
      chk_cnt("post_reset_total_hits");

      chk("pulse_queue_drained", pq.size(), 0);
      chk("summary_queue_drained", sq.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
